ahb_slave_if_param: RTL and testbench

Parametrised AHB slave front end for the AHB-to-APB bridge. It decodes a configurable number of equal-size peripheral regions and pipelines address, write data and direction toward the bridge FSM. It holds its pipeline during wait states, forwards bridge back-pressure on Hreadyout, and returns a two-cycle AHB ERROR response for active transfers to unmapped addresses. It replaces the fixed three-peripheral, OKAY-only slave interface.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_slave_if_param_if.sv | 40 ++++
 rtl/ahb_addr_decoder.sv | 30 +++
 rtl/ahb_slave_if_param.sv | 106 ++++++++++
 tb/tb_ahb_slave_if_param.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB codes, error-FSM state type and region-bound helper for the
// parametrised AHB slave front end.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        OK   = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } err_state_t;

    // Exclusive end of region idx; wide enough that the top region never wraps.
    function automatic logic [63:0] region_end(input logic [63:0] base,
                                               input int unsigned idx,
                                               input int unsigned shift);
        return base + ((64'(idx) + 64'd1) << shift);
    endfunction

endpackage

// File: rtl/ahb_slave_if_param_if.sv
// Bus-side signal bundle for ahb_slave_if_param: AHB inputs, bridge
// handshake and the pipelined outputs toward the bridge FSM.
interface ahb_slave_if_param_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 3
);
    logic                Hwrite;
    logic                Hreadyin;
    logic [1:0]          Htrans;
    logic [ADDR_W-1:0]   Haddr;
    logic [DATA_W-1:0]   Hwdata;
    logic [DATA_W-1:0]   Prdata;
    logic                bridge_ready;

    logic                valid;
    logic [ADDR_W-1:0]   Haddr1;
    logic [ADDR_W-1:0]   Haddr2;
    logic [DATA_W-1:0]   Hwdata1;
    logic [DATA_W-1:0]   Hwdata2;
    logic                Hwritereg;
    logic                Hwritereg1;
    logic [NUM_SLV-1:0]  tempselx;
    logic [DATA_W-1:0]   Hrdata;
    logic [1:0]          Hresp;
    logic                Hreadyout;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, bridge_ready,
        output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
               tempselx, Hrdata, Hresp, Hreadyout
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, bridge_ready,
        input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
               tempselx, Hrdata, Hresp, Hreadyout
    );

endinterface

// File: rtl/ahb_addr_decoder.sv
// Combinational decode of Haddr into NUM_SLV equal power-of-two regions
// starting at BASE_ADDR; produces a one-hot select and a mapped flag.
module ahb_addr_decoder
    import ahb_pkg::*;
#(
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        NUM_SLV      = 3,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = 32'h8000_0000,
    parameter int unsigned        REGION_SHIFT = 26
) (
    input  logic [ADDR_W-1:0]  Haddr,
    output logic [NUM_SLV-1:0] sel,
    output logic               mapped
);

    logic [ADDR_W:0] addr_ext;
    assign addr_ext = {1'b0, Haddr};

    // Bounds are compared one bit wider than the bus so an end of 2^ADDR_W stays exact.
    for (genvar g = 0; g < NUM_SLV; g++) begin : g_region
        localparam logic [ADDR_W:0] LO =
            (ADDR_W+1)'(64'(BASE_ADDR) + (64'(g) << REGION_SHIFT));
        localparam logic [ADDR_W:0] HI =
            (ADDR_W+1)'(region_end(64'(BASE_ADDR), g, REGION_SHIFT));
        assign sel[g] = (addr_ext >= LO) && (addr_ext < HI);
    end

    assign mapped = |sel;

endmodule

// File: rtl/ahb_slave_if_param.sv
// AHB slave front end for the AHB-to-APB bridge: region decode, address/data/
// direction pipeline with wait-state hold, and a two-cycle ERROR response.
module ahb_slave_if_param
    import ahb_pkg::*;
#(
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        DATA_W       = 32,
    parameter int unsigned        NUM_SLV      = 3,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = 32'h8000_0000,
    parameter int unsigned        REGION_SHIFT = 26
) (
    input logic                  Hclk,
    input logic                  Hresetn,
    ahb_slave_if_param_if.slave  bus
);

    logic [NUM_SLV-1:0] sel;
    logic               mapped;
    logic               active;

    logic [ADDR_W-1:0]  haddr1_q, haddr2_q;
    logic [DATA_W-1:0]  hwdata1_q, hwdata2_q;
    logic               hwrite1_q, hwrite2_q;

    err_state_t         state_q;
    logic [1:0]         hresp_q;
    logic               err_rdy_q;

    ahb_addr_decoder #(
        .ADDR_W       (ADDR_W),
        .NUM_SLV      (NUM_SLV),
        .BASE_ADDR    (BASE_ADDR),
        .REGION_SHIFT (REGION_SHIFT)
    ) u_dec (
        .Haddr  (bus.Haddr),
        .sel    (sel),
        .mapped (mapped)
    );

    assign active = (bus.Htrans == HTRANS_NONSEQ) || (bus.Htrans == HTRANS_SEQ);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
        end else if (bus.Hreadyin) begin
            haddr1_q  <= bus.Haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= bus.Hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite1_q <= bus.Hwrite;
            hwrite2_q <= hwrite1_q;
        end
    end

    // err_rdy_q pre-computes the ERR2 Hreadyout so only the OK case is combinational.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= OK;
            hresp_q   <= HRESP_OKAY;
            err_rdy_q <= 1'b0;
        end else begin
            case (state_q)
                OK: begin
                    if (bus.Hreadyin && active && !mapped) begin
                        state_q   <= ERR1;
                        hresp_q   <= HRESP_ERROR;
                        err_rdy_q <= 1'b0;
                    end
                end
                ERR1: begin
                    state_q   <= ERR2;
                    hresp_q   <= HRESP_ERROR;
                    err_rdy_q <= 1'b1;
                end
                ERR2: begin
                    state_q   <= OK;
                    hresp_q   <= HRESP_OKAY;
                    err_rdy_q <= 1'b0;
                end
                default: begin
                    state_q   <= OK;
                    hresp_q   <= HRESP_OKAY;
                    err_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid      = Hresetn && bus.Hreadyin && active && mapped && (state_q == OK);
    assign bus.tempselx   = Hresetn ? sel : '0;
    assign bus.Haddr1     = haddr1_q;
    assign bus.Haddr2     = haddr2_q;
    assign bus.Hwdata1    = hwdata1_q;
    assign bus.Hwdata2    = hwdata2_q;
    assign bus.Hwritereg  = hwrite1_q;
    assign bus.Hwritereg1 = hwrite2_q;
    assign bus.Hrdata     = bus.Prdata;
    assign bus.Hresp      = hresp_q;
    assign bus.Hreadyout  = (state_q == OK) ? bus.bridge_ready : err_rdy_q;

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Directed bench for ahb_slave_if_param: default 3-region map and an
// 8-region / 16 MB map, each with its own interface and reset.
module tb_ahb_slave_if_param;
    import ahb_pkg::*;

    logic Hclk;
    logic rst1_n, rst2_n;
    int   checks = 0;
    int   errors = 0;

    ahb_slave_if_param_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) bus1 ();
    ahb_slave_if_param_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(8)) bus2 ();

    ahb_slave_if_param #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3),
        .BASE_ADDR(32'h8000_0000), .REGION_SHIFT(26)
    ) dut1 (
        .Hclk(Hclk), .Hresetn(rst1_n), .bus(bus1)
    );

    ahb_slave_if_param #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(8),
        .BASE_ADDR(32'h8000_0000), .REGION_SHIFT(24)
    ) dut2 (
        .Hclk(Hclk), .Hresetn(rst2_n), .bus(bus2)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        bus1.Hwrite = 1'b1;  bus1.Hreadyin = 1'b1;  bus1.Htrans = HTRANS_NONSEQ;
        bus1.Haddr = 32'h8000_0010;  bus1.Hwdata = '0;  bus1.Prdata = '0;
        bus1.bridge_ready = 1'b0;
        bus2.Hwrite = 1'b0;  bus2.Hreadyin = 1'b1;  bus2.Htrans = HTRANS_IDLE;
        bus2.Haddr = '0;  bus2.Hwdata = '0;  bus2.Prdata = '0;
        bus2.bridge_ready = 1'b1;

        // reset state
        #12;
        chk("rst_haddr1", bus1.Haddr1, 0);
        chk("rst_haddr2", bus1.Haddr2, 0);
        chk("rst_hwdata1", bus1.Hwdata1, 0);
        chk("rst_hwrite1", bus1.Hwritereg1, 0);
        chk("rst_hresp", bus1.Hresp, 2'b00);
        chk("rst_valid", bus1.valid, 0);
        chk("rst_tempselx", bus1.tempselx, 0);
        chk("rst_hreadyout_lo", bus1.Hreadyout, 0);
        bus1.bridge_ready = 1'b1;
        #1;
        chk("rst_hreadyout_hi", bus1.Hreadyout, 1);

        // NONSEQ write to region 0
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        #1;
        chk("wr_valid", bus1.valid, 1);
        chk("wr_tempselx", bus1.tempselx, 3'b001);
        tick();
        chk("wr_haddr1", bus1.Haddr1, 32'h8000_0010);
        chk("wr_hwrite1", bus1.Hwritereg, 1);

        // NONSEQ read to region 2 while write data is on Hwdata
        bus1.Hwrite = 1'b0;  bus1.Haddr = 32'h8800_0004;
        bus1.Hwdata = 32'h1111_2222;  bus1.Prdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_tempselx", bus1.tempselx, 3'b100);
        chk("rd_valid", bus1.valid, 1);
        chk("rd_hresp", bus1.Hresp, 2'b00);
        chk("rd_hrdata", bus1.Hrdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_haddr2", bus1.Haddr2, 32'h8000_0010);
        chk("wr_hwrite2", bus1.Hwritereg1, 1);
        chk("rd_haddr1", bus1.Haddr1, 32'h8800_0004);
        chk("rd_hwrite1", bus1.Hwritereg, 0);
        chk("wr_hwdata1", bus1.Hwdata1, 32'h1111_2222);
        bus1.Prdata = 32'h0BAD_F00D;
        #1;
        chk("rd_hrdata2", bus1.Hrdata, 32'h0BAD_F00D);

        // last byte of region 2 is still mapped
        bus1.Haddr = 32'h8BFF_FFFF;
        #1;
        chk("top_edge_sel", bus1.tempselx, 3'b100);
        chk("top_edge_valid", bus1.valid, 1);
        tick();

        // one past the last region: two-cycle ERROR, transfers in ERR ignored
        bus1.Haddr = 32'h8C00_0000;
        #1;
        chk("unm_valid", bus1.valid, 0);
        chk("unm_tempselx", bus1.tempselx, 0);
        chk("unm_hresp0", bus1.Hresp, 2'b00);
        tick();
        chk("err1_hresp", bus1.Hresp, 2'b01);
        chk("err1_hready", bus1.Hreadyout, 0);
        chk("err1_valid", bus1.valid, 0);
        bus1.Haddr = 32'h8000_0000;
        #1;
        chk("err1_mapped_valid", bus1.valid, 0);
        bus1.Haddr = 32'h8C00_0000;
        tick();
        chk("err2_hresp", bus1.Hresp, 2'b01);
        chk("err2_hready", bus1.Hreadyout, 1);
        tick();
        chk("ok_hresp", bus1.Hresp, 2'b00);
        chk("ok_hready", bus1.Hreadyout, 1);
        bus1.Htrans = HTRANS_IDLE;
        tick();
        chk("idle_hresp", bus1.Hresp, 2'b00);

        // BUSY to unmapped: no error
        bus1.Htrans = HTRANS_BUSY;
        tick();
        chk("busy_hresp", bus1.Hresp, 2'b00);

        // BASE_ADDR - 1 is unmapped
        bus1.Htrans = HTRANS_NONSEQ;  bus1.Haddr = 32'h7FFF_FFFF;
        #1;
        chk("below_sel", bus1.tempselx, 0);
        tick();
        chk("below_hresp", bus1.Hresp, 2'b01);
        chk("below_hready", bus1.Hreadyout, 0);
        bus1.Htrans = HTRANS_IDLE;
        tick();
        tick();
        chk("below_ok", bus1.Hresp, 2'b00);

        // burst into region 1 with a 2-cycle Hreadyin stall
        bus1.Htrans = HTRANS_NONSEQ;  bus1.Hwrite = 1'b1;
        bus1.Haddr = 32'h8400_0000;  bus1.Hwdata = 32'hA0A0_0000;
        tick();
        bus1.Htrans = HTRANS_SEQ;  bus1.Haddr = 32'h8400_0004;
        bus1.Hwdata = 32'hA1A1_0001;
        #1;
        chk("burst_sel", bus1.tempselx, 3'b010);
        tick();
        bus1.Hreadyin = 1'b0;  bus1.Haddr = 32'h8400_0008;
        bus1.Hwdata = 32'hA2A2_0002;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_valid", bus1.valid, 0);
            tick();
            chk("stall_haddr1", bus1.Haddr1, 32'h8400_0004);
            chk("stall_hwdata1", bus1.Hwdata1, 32'hA1A1_0001);
            chk("stall_haddr2", bus1.Haddr2, 32'h8400_0000);
        end
        bus1.Hreadyin = 1'b1;
        #1;
        chk("resume_valid", bus1.valid, 1);
        tick();
        chk("resume_haddr1", bus1.Haddr1, 32'h8400_0008);
        chk("resume_hwdata1", bus1.Hwdata1, 32'hA2A2_0002);
        chk("resume_haddr2", bus1.Haddr2, 32'h8400_0004);
        chk("resume_hwdata2", bus1.Hwdata2, 32'hA1A1_0001);

        // bridge back-pressure in OK
        bus1.Htrans = HTRANS_IDLE;
        bus1.bridge_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_hready", bus1.Hreadyout, 0);
            chk("bp_hresp", bus1.Hresp, 2'b00);
            tick();
        end
        bus1.bridge_ready = 1'b1;
        #1;
        chk("bp_release", bus1.Hreadyout, 1);

        // 8 regions of 16 MB
        bus2.Htrans = HTRANS_NONSEQ;  bus2.Haddr = 32'h8700_0000;
        #1;
        chk("n8_sel7", bus2.tempselx, 8'b1000_0000);
        chk("n8_valid", bus2.valid, 1);
        bus2.Haddr = 32'h8300_0010;
        #1;
        chk("n8_sel3", bus2.tempselx, 8'b0000_1000);
        tick();
        bus2.Haddr = 32'h8800_0000;
        #1;
        chk("n8_unm_sel", bus2.tempselx, 0);
        chk("n8_unm_valid", bus2.valid, 0);
        tick();
        chk("n8_err1_hresp", bus2.Hresp, 2'b01);
        chk("n8_err1_hready", bus2.Hreadyout, 0);
        rst2_n = 1'b0;
        #1;
        chk("n8_rst_hresp", bus2.Hresp, 2'b00);
        chk("n8_rst_hready", bus2.Hreadyout, 1);
        chk("n8_rst_haddr1", bus2.Haddr1, 0);
        bus2.Htrans = HTRANS_IDLE;
        rst2_n = 1'b1;
        tick();
        chk("n8_post_hresp", bus2.Hresp, 2'b00);
        chk("n8_post_hready", bus2.Hreadyout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
